// File: rtl/pcpi_issue_ctrl.sv
// rtl/pcpi_issue_ctrl.sv - nibble-serial host front end that issues one PCPI instruction and reads back its result
module pcpi_issue_ctrl #(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  nib_in,
  input  logic        nib_strobe,
  input  logic        res_ack,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  input  logic        pcpi_ready,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  output logic [3:0]  res_nib,
  output logic        res_valid,
  output logic        busy,
  output logic        err,
  output logic [2:0]  load_cnt
);

  localparam int TW = $clog2(WAIT_TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {LOAD, ISSUE, READOUT} state_t;

  state_t        state;
  logic [2:0]    stb_sync;
  logic [2:0]    ack_sync;
  logic          stb_pulse;
  logic          ack_pulse;
  logic [31:0]   result;
  logic [2:0]    rd_cnt;
  logic [TW-1:0] tcnt;
  logic          wait_seen;

  // [0],[1] form the synchronizer, [2] is the delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_sync <= '0;
      ack_sync <= '0;
    end else begin
      stb_sync <= {stb_sync[1:0], nib_strobe};
      ack_sync <= {ack_sync[1:0], res_ack};
    end
  end

  assign stb_pulse = stb_sync[1] & ~stb_sync[2];
  assign ack_pulse = ack_sync[1] & ~ack_sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      pcpi_valid <= 1'b0;
      pcpi_insn  <= '0;
      result     <= '0;
      res_valid  <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      load_cnt   <= '0;
      rd_cnt     <= '0;
      tcnt       <= '0;
      wait_seen  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (stb_pulse) begin
            pcpi_insn[{load_cnt, 2'b00} +: 4] <= nib_in;
            if (load_cnt == 3'd0) err <= 1'b0;
            load_cnt <= load_cnt + 3'd1;
            if (load_cnt == 3'd7) begin
              pcpi_valid <= 1'b1;
              busy       <= 1'b1;
              tcnt       <= '0;
              wait_seen  <= 1'b0;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // ready outranks a timeout landing on the same edge
          if (pcpi_ready) begin
            pcpi_valid <= 1'b0;
            busy       <= 1'b0;
            result     <= pcpi_wr ? pcpi_rd : 32'h0;
            if (pcpi_wr) begin
              res_valid <= 1'b1;
              rd_cnt    <= '0;
              state     <= READOUT;
            end else begin
              state <= LOAD;
            end
          end else if (!wait_seen && !pcpi_wait && tcnt == T_LAST) begin
            pcpi_valid <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b1;
            state      <= LOAD;
          end else begin
            if (pcpi_wait) wait_seen <= 1'b1;
            if (!wait_seen) tcnt <= tcnt + TW'(1);
          end
        end
        READOUT: begin
          if (ack_pulse) begin
            rd_cnt <= rd_cnt + 3'd1;
            if (rd_cnt == 3'd7) begin
              res_valid <= 1'b0;
              state     <= LOAD;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign res_nib = res_valid ? result[{rd_cnt, 2'b00} +: 4] : 4'h0;

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// tb/tb_pcpi_issue_ctrl.sv - directed bench with an edge-history reference model for pcpi_issue_ctrl
module tb_pcpi_issue_ctrl;
  localparam int WT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  nib_in = '0;
  logic        nib_strobe = 1'b0;
  logic        res_ack = 1'b0;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready = 1'b0;
  logic        pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = '0;
  logic        pcpi_wait = 1'b0;
  logic [3:0]  res_nib;
  logic        res_valid;
  logic        busy;
  logic        err;
  logic [2:0]  load_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pcpi_issue_ctrl #(.WAIT_TIMEOUT(WT)) dut (
    .clk(clk), .rst_n(rst_n), .nib_in(nib_in), .nib_strobe(nib_strobe), .res_ack(res_ack),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr),
    .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .res_nib(res_nib), .res_valid(res_valid),
    .busy(busy), .err(err), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = collecting, 1 = waiting on coprocessor, 2 = returning result
  int          m_phase = 0;
  int          m_nibs = 0;
  int          m_reads = 0;
  int          edge_n = 0;
  int          m_issue_edge = 0;
  bit          m_claimed = 0;
  logic [31:0] m_insn = '0;
  logic [31:0] m_result = '0;
  logic        m_valid = 0;
  logic        m_err = 0;
  logic        m_res_valid = 0;
  bit          stb_h[$];
  bit          ack_h[$];

  task automatic model_step();
    bit sp, ap;
    if (!rst_n) begin
      m_phase = 0; m_nibs = 0; m_reads = 0; edge_n = 0; m_claimed = 0;
      m_insn = '0; m_result = '0; m_valid = 0; m_err = 0; m_res_valid = 0;
      stb_h = '{0, 0, 0};
      ack_h = '{0, 0, 0};
      return;
    end
    edge_n++;
    // a host edge acts two clock edges after it is first sampled high
    sp = stb_h[$-1] && !stb_h[$-2];
    ap = ack_h[$-1] && !ack_h[$-2];
    stb_h.push_back(nib_strobe); void'(stb_h.pop_front());
    ack_h.push_back(res_ack);    void'(ack_h.pop_front());
    if (m_phase == 0) begin
      if (sp) begin
        m_insn[4*m_nibs +: 4] = nib_in;
        if (m_nibs == 0) m_err = 0;
        m_nibs++;
        if (m_nibs == 8) begin
          m_nibs = 0; m_valid = 1; m_phase = 1;
          m_issue_edge = edge_n; m_claimed = 0;
        end
      end
    end else if (m_phase == 1) begin
      if (pcpi_ready) begin
        m_valid = 0;
        m_result = pcpi_wr ? pcpi_rd : 32'h0;
        if (pcpi_wr) begin m_phase = 2; m_reads = 0; m_res_valid = 1; end
        else m_phase = 0;
      end else if (!m_claimed && !pcpi_wait && (edge_n - m_issue_edge) == WT) begin
        m_valid = 0; m_err = 1; m_phase = 0;
      end else if (pcpi_wait) begin
        m_claimed = 1;
      end
    end else begin
      if (ap) begin
        m_reads++;
        if (m_reads == 8) begin m_reads = 0; m_res_valid = 0; m_phase = 0; end
      end
    end
  endtask

  initial begin
    stb_h = '{0, 0, 0};
    ack_h = '{0, 0, 0};
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("valid", 32'(pcpi_valid), 32'(m_valid));
    chk("insn", pcpi_insn, m_insn);
    chk("res_valid", 32'(res_valid), 32'(m_res_valid));
    chk("busy", 32'(busy), 32'(m_phase == 1));
    chk("err", 32'(err), 32'(m_err));
    chk("load_cnt", 32'(load_cnt), 32'(m_nibs));
    if (m_res_valid) chk("res_nib", 32'(res_nib), 32'(m_result[4*m_reads +: 4]));
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic strobe_nib(input logic [3:0] n);
    nib_in = n; nib_strobe = 1'b1;
    repeat (3) step();
    nib_strobe = 1'b0;
    repeat (3) step();
  endtask

  // returns just after the edge that raises pcpi_valid
  task automatic load_word(input logic [31:0] w, input int from);
    for (int i = from; i < 8; i++) begin
      if (i < 7) strobe_nib(w[4*i +: 4]);
      else begin
        nib_in = w[31:28]; nib_strobe = 1'b1;
        repeat (3) step();
        nib_strobe = 1'b0;
      end
    end
  endtask

  task automatic ack_seq(input logic [31:0] r);
    for (int i = 0; i < 8; i++) begin
      chk("ack_nib", 32'(res_nib), 32'(r[4*i +: 4]));
      res_ack = 1'b1;
      repeat (3) step();
      res_ack = 1'b0;
      repeat (3) step();
    end
    chk("readout_done", 32'(res_valid), 32'd0);
  endtask

  task automatic pulse_ready(input logic wr, input logic [31:0] rd);
    pcpi_ready = 1'b1; pcpi_wr = wr; pcpi_rd = rd;
    step();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_wait = 1'b0;
  endtask

  initial begin
    logic [31:0] dead;
    logic [31:0] cafe;
    dead = 32'hDEADBEEF;
    cafe = 32'hCAFEF00D;

    // reset with inputs toggling
    for (int i = 0; i < 6; i++) begin
      step();
      nib_strobe = ~nib_strobe; res_ack = ~res_ack; pcpi_ready = ~pcpi_ready;
      pcpi_wait = ~pcpi_wait; nib_in = 4'(i * 3);
    end
    chk("rst_valid", 32'(pcpi_valid), 32'd0);
    chk("rst_insn", pcpi_insn, 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_nib", 32'(res_nib), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_load_cnt", 32'(load_cnt), 32'd0);
    nib_strobe = 0; res_ack = 0; pcpi_ready = 0; pcpi_wait = 0;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("post_rst_load_cnt", 32'(load_cnt), 32'd0);

    // full handshake: wait then ready with write
    load_word(32'h12345678, 0);
    chk("t2_insn", pcpi_insn, 32'h12345678);
    chk("t2_valid", 32'(pcpi_valid), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    step();
    pcpi_wait = 1'b1;
    repeat (8) step();
    pulse_ready(1'b1, dead);
    chk("t2_valid_drop", 32'(pcpi_valid), 32'd0);
    chk("t2_res_valid", 32'(res_valid), 32'd1);
    chk("t2_res_nib0", 32'(res_nib), 32'hF);
    strobe_nib(4'h9);
    chk("t2_readout_strobe", 32'(load_cnt), 32'd0);
    ack_seq(dead);

    // timeout
    load_word(32'hA1B2C3D4, 0);
    repeat (WT - 1) step();
    chk("t3_valid_before", 32'(pcpi_valid), 32'd1);
    chk("t3_err_before", 32'(err), 32'd0);
    step();
    chk("t3_valid_timeout", 32'(pcpi_valid), 32'd0);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    strobe_nib(4'h3);
    chk("t3_err_cleared", 32'(err), 32'd0);
    chk("t3_load_cnt", 32'(load_cnt), 32'd1);

    // ready without write, strobe during ISSUE
    load_word(32'h89ABCDE3, 1);
    chk("t4_insn", pcpi_insn, 32'h89ABCDE3);
    strobe_nib(4'h5);
    chk("t4_issue_strobe", 32'(load_cnt), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    pulse_ready(1'b0, 32'hFFFFFFFF);
    chk("t4_valid", 32'(pcpi_valid), 32'd0);
    chk("t4_res_valid", 32'(res_valid), 32'd0);
    chk("t4_busy_after", 32'(busy), 32'd0);
    step();
    chk("t4_res_valid_later", 32'(res_valid), 32'd0);

    // ready on exactly the timeout edge
    load_word(32'h0F1E2D3C, 0);
    repeat (WT - 1) step();
    pulse_ready(1'b1, cafe);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_valid", 32'(pcpi_valid), 32'd0);
    chk("t5_res_valid", 32'(res_valid), 32'd1);
    chk("t5_res_nib0", 32'(res_nib), 32'hD);
    strobe_nib(4'h7);
    chk("t5_readout_strobe", 32'(load_cnt), 32'd0);
    ack_seq(cafe);

    // asynchronous reset mid-load
    for (int i = 0; i < 5; i++) strobe_nib(4'(i + 1));
    chk("t6_load_cnt5", 32'(load_cnt), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_load_cnt", 32'(load_cnt), 32'd0);
    chk("t6_rst_insn", pcpi_insn, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // asynchronous reset mid-ISSUE
    load_word(32'h2468ACE1, 0);
    repeat (3) step();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(pcpi_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    load_word(32'h13579BDF, 0);
    chk("t6_insn", pcpi_insn, 32'h13579BDF);
    chk("t6_valid", 32'(pcpi_valid), 32'd1);
    step();
    pulse_ready(1'b0, 32'h0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
